sc_fifo2: RTL and testbench
===========================

Name: sc_fifo2

Overview:
- Single-clock synchronous FIFO with registered read data, full/empty flags and a free-space ("margin") count.
- Used as a slave-channel buffer in the MCDF data path.
- The margin output lets an upstream arbiter see how many more words can be accepted.

Parameters:
- DATA_WIDTH, 32, width of each stored word in bits.
- DATA_DEPTH, 64, number of entries. Must be a power of two, at least 4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- wr_en  input  1  write request.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds DATA_DEPTH words.
- FIFO_margin_o  output  $clog2(DATA_DEPTH) (6 at default)  free entries, saturated at DATA_DEPTH-1.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - read/write pointers and occupancy count cleared to 0.
  - data_out=0, empty=1, full=0, FIFO_margin_o=DATA_DEPTH-1 (63).
  - Memory contents need not be cleared.
- Internal state:
  - write pointer and read pointer, each $clog2(DATA_DEPTH) bits; wrap naturally from DATA_DEPTH-1 to 0.
  - occupancy count, $clog2(DATA_DEPTH)+1 bits, range 0..DATA_DEPTH.
- Write: accepted when wr_en=1 and full=0 at the rising edge.
  - data_in is stored at the write pointer; the write pointer increments.
  - Writes while full are dropped; no state changes.
- Read: accepted when rd_en=1 and empty=0 at the rising edge.
  - mem[read pointer] is loaded into data_out at that same edge; the read pointer increments.
  - Latency: the word is visible on data_out one clock after rd_en is sampled.
  - Reads while empty are ignored; data_out holds its previous value.
- Acceptance decisions use the flags as they were before the edge.
- Simultaneous read and write:
  - Both accepted when 0 < count < DATA_DEPTH; count unchanged.
  - When empty: write only.
  - When full: read only; the write is dropped.
- Count update: +1 on accepted write only, -1 on accepted read only, otherwise unchanged.
- Flags are combinational from count:
  - empty = (count==0).
  - full = (count==DATA_DEPTH).
- FIFO_margin_o = DATA_DEPTH - count, clamped to DATA_DEPTH-1.
  - A completely empty FIFO (64 free) reports 63.
- Ordering is strict first-in, first-out; no data loss when no overflow occurs.
- Reset asserted mid-operation discards all stored words; the FIFO comes out of reset empty.

Optional Feature:
- Macro: SC_FIFO2_ERR_FLAGS_EN.
- When defined, adds two outputs, overflow and underflow, each 1 bit, registered, reset to 0:
  - overflow pulses high for exactly one cycle after an edge where wr_en=1 and full=1, and rd_en did not make room.
  - underflow pulses high for exactly one cycle after an edge where rd_en=1 and empty=1.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> empty=1, full=0, data_out=0, FIFO_margin_o=63. Asserting rst_n asynchronously between edges clears the outputs immediately.
- Write 10 random words back-to-back, then rd_en for 10 cycles:
  - during the writes -> margin steps 63(empty),63,62...54; empty=0 after the first write.
  - during the reads -> data_out matches the write order, each word one cycle after its read edge.
  - after the 10th read -> empty=1, margin=63.
- Fill with 64 words (0..63) -> full=1, margin=0.
  - 65th write (value 0xDEAD) is dropped.
  - Reading 64 words returns 0..63; 0xDEAD never appears.
- Read on empty: after draining, assert rd_en 3 cycles -> data_out holds the last word; empty stays 1; pointers unchanged (next write/read returns the new word).
- Simultaneous rd_en=wr_en=1 for 8 cycles with 5 words stored -> count stays 5, margin stays 59, output order preserved across pointer wrap-around (run with pointers near index 62).
- With SC_FIFO2_ERR_FLAGS_EN: write while full -> overflow=1 for exactly one cycle; read while empty -> underflow=1 for exactly one cycle.

Source files
------------

// File: rtl/sc_fifo2.sv
// sc_fifo2 - single-clock synchronous FIFO used as a slave-channel buffer in
// the MCDF data path. Read data is registered (one cycle after rd_en is
// sampled), and the FIFO reports empty/full plus a free-space margin that an
// upstream arbiter uses to decide how many more words it may send.
//
// Optional build macro: SC_FIFO2_ERR_FLAGS_EN adds one-cycle overflow and
// underflow pulse outputs. With the macro undefined those ports do not exist.
//
// Flags and margin are held in registers that are loaded from the next
// occupancy count, so they always equal the combinational functions of the
// current count while being driven straight from flops.
module sc_fifo2 #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  input  logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
`ifdef SC_FIFO2_ERR_FLAGS_EN
  output logic                          overflow,
  output logic                          underflow,
`endif
  output logic [$clog2(DATA_DEPTH)-1:0] FIFO_margin_o
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;

  // Storage and pointers
  logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  empty_r;
  logic                  full_r;
  logic [AW-1:0]         margin_r;

  // Next-state helpers
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [CW-1:0]         count_nxt_s;
  logic [CW-1:0]         free_nxt_s;
  logic [AW-1:0]         margin_nxt_s;
  logic                  empty_nxt_s;
  logic                  full_nxt_s;

`ifdef SC_FIFO2_ERR_FLAGS_EN
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  overflow_nxt_s;
  logic                  underflow_nxt_s;
`endif

  // Accept/reject decisions based on the flags as they stand before the edge
  always_comb begin
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    if (wr_en && !full_r) begin
      wr_acc_s = 1'b1;
    end else begin
      wr_acc_s = 1'b0;
    end
    if (rd_en && !empty_r) begin
      rd_acc_s = 1'b1;
    end else begin
      rd_acc_s = 1'b0;
    end
  end

  // Occupancy update: a simultaneous accepted read and write cancel out
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Flags and free-space margin derived from the next count; margin saturates
  // one below the depth so it fits in AW bits (empty FIFO reports depth-1)
  always_comb begin
    empty_nxt_s  = 1'b0;
    full_nxt_s   = 1'b0;
    free_nxt_s   = CW'(DATA_DEPTH) - count_nxt_s;
    margin_nxt_s = {AW{1'b0}};
    if (count_nxt_s == {CW{1'b0}}) begin
      empty_nxt_s = 1'b1;
    end else begin
      empty_nxt_s = 1'b0;
    end
    if (count_nxt_s == CW'(DATA_DEPTH)) begin
      full_nxt_s = 1'b1;
    end else begin
      full_nxt_s = 1'b0;
    end
    if (free_nxt_s > CW'(DATA_DEPTH - 1)) begin
      margin_nxt_s = {AW{1'b1}};
    end else begin
      margin_nxt_s = free_nxt_s[AW-1:0];
    end
  end

  // Pointer, count, flag and margin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      margin_r <= {AW{1'b1}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r  <= count_nxt_s;
      empty_r  <= empty_nxt_s;
      full_r   <= full_nxt_s;
      margin_r <= margin_nxt_s;
    end
  end

  // Storage array write port; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Registered read port; holds the last word when a read is not accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_acc_s) begin
      data_out_r <= mem_r[rd_ptr_r];
    end
  end

`ifdef SC_FIFO2_ERR_FLAGS_EN
  // Error conditions: write into a full FIFO with no read freeing a slot,
  // and read from an empty FIFO
  always_comb begin
    overflow_nxt_s  = 1'b0;
    underflow_nxt_s = 1'b0;
    if (wr_en && full_r && !rd_en) begin
      overflow_nxt_s = 1'b1;
    end else begin
      overflow_nxt_s = 1'b0;
    end
    if (rd_en && empty_r) begin
      underflow_nxt_s = 1'b1;
    end else begin
      underflow_nxt_s = 1'b0;
    end
  end

  // One-cycle error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

  assign data_out      = data_out_r;
  assign empty         = empty_r;
  assign full          = full_r;
  assign FIFO_margin_o = margin_r;

endmodule

// File: tb/tb_sc_fifo2.sv
// tb_sc_fifo2 - directed self-checking bench for sc_fifo2 (default 32x64).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_sc_fifo2;

  localparam int DW = 32;
  localparam int DD = 64;
  localparam int AW = 6;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic          wr_en;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic [AW-1:0] margin;
`ifdef SC_FIFO2_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sc_fifo2 #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .data_out      (data_out),
    .empty         (empty),
    .full          (full),
`ifdef SC_FIFO2_ERR_FLAGS_EN
    .overflow      (overflow),
    .underflow     (underflow),
`endif
    .FIFO_margin_o (margin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] v);
    wr_en   = 1'b1;
    rd_en   = 1'b0;
    data_in = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic read_word();
    rd_en = 1'b1;
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
  endtask

  logic [31:0] w [10];
  logic [31:0] q [$];
  logic [31:0] exp_v;

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_empty",  32'(empty), 32'd1);
    check_eq("rst_full",   32'(full), 32'd0);
    check_eq("rst_dout",   data_out, 32'h0);
    check_eq("rst_margin", 32'(margin), 32'd63);
`ifdef SC_FIFO2_ERR_FLAGS_EN
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_udf", 32'(underflow), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Ten words back to back, then ten consecutive reads
    for (int i = 0; i < 10; i++) w[i] = 32'h1234_5678 ^ (32'h0101_0101 * 32'(i));
    check_eq("wr10_margin0", 32'(margin), 32'd63);
    for (int i = 0; i < 10; i++) begin
      write_word(w[i]);
      check_eq("wr10_margin", 32'(margin), 32'(63 - i));
      check_eq("wr10_empty",  32'(empty), 32'd0);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("rd10_data",   data_out, w[i]);
      check_eq("rd10_margin", 32'(margin), (i == 9) ? 32'd63 : 32'(55 + i));
    end
    rd_en = 1'b0;
    check_eq("rd10_empty", 32'(empty), 32'd1);

    // Fill to full, drop an extra write, drain in order
    for (int i = 0; i < 64; i++) write_word(32'(i));
    check_eq("fill_full",   32'(full), 32'd1);
    check_eq("fill_margin", 32'(margin), 32'd0);
    check_eq("fill_empty",  32'(empty), 32'd0);
    write_word(32'h0000_DEAD);
    check_eq("ovw_full",   32'(full), 32'd1);
    check_eq("ovw_margin", 32'(margin), 32'd0);
    for (int i = 0; i < 64; i++) begin
      read_word();
      check_eq("drain_data", data_out, 32'(i));
    end
    check_eq("drain_empty",  32'(empty), 32'd1);
    check_eq("drain_margin", 32'(margin), 32'd63);

    // Reads on empty are ignored and leave the pointers alone
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rde_hold",  data_out, 32'd63);
      check_eq("rde_empty", 32'(empty), 32'd1);
    end
    rd_en = 1'b0;
    write_word(32'h0000_55AA);
    read_word();
    check_eq("rde_next", data_out, 32'h0000_55AA);
    check_eq("rde_next_empty", 32'(empty), 32'd1);

    // Move both pointers to index 60 (currently 11)
    for (int i = 0; i < 49; i++) write_word(32'(i));
    for (int i = 0; i < 49; i++) read_word();
    check_eq("adv_empty", 32'(empty), 32'd1);

    // Five stored, then eight simultaneous read+write across the wrap
    for (int i = 0; i < 5; i++) begin
      write_word(32'hC000_0000 + 32'(i));
      q.push_back(32'hC000_0000 + 32'(i));
    end
    check_eq("sim_margin0", 32'(margin), 32'd59);
    for (int j = 0; j < 8; j++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      data_in = 32'hD000_0000 + 32'(j);
      tick();
      exp_v = q.pop_front();
      q.push_back(32'hD000_0000 + 32'(j));
      check_eq("sim_data",   data_out, exp_v);
      check_eq("sim_margin", 32'(margin), 32'd59);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      read_word();
      exp_v = q.pop_front();
      check_eq("sim_drain", data_out, exp_v);
    end
    check_eq("sim_empty", 32'(empty), 32'd1);

`ifdef SC_FIFO2_ERR_FLAGS_EN
    // Overflow and underflow pulses last exactly one cycle
    for (int i = 0; i < 64; i++) write_word(32'(i));
    check_eq("ovf_pre", 32'(overflow), 32'd0);
    write_word(32'h0000_BEEF);
    check_eq("ovf_pulse", 32'(overflow), 32'd1);
    tick();
    check_eq("ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 64; i++) read_word();
    check_eq("udf_pre", 32'(underflow), 32'd0);
    read_word();
    check_eq("udf_pulse", 32'(underflow), 32'd1);
    tick();
    check_eq("udf_clear", 32'(underflow), 32'd0);
`endif

    // Asynchronous reset mid-operation discards stored words
    write_word(32'h0000_0007);
    write_word(32'h0000_0008);
    read_word();
    check_eq("ar_pre", data_out, 32'h0000_0007);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("ar_dout",   data_out, 32'h0);
    check_eq("ar_empty",  32'(empty), 32'd1);
    check_eq("ar_full",   32'(full), 32'd0);
    check_eq("ar_margin", 32'(margin), 32'd63);
    #1;
    rst_n = 1'b1;
    tick();
    write_word(32'h0000_0009);
    read_word();
    check_eq("ar_post", data_out, 32'h0000_0009);
    check_eq("ar_post_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
